// File: rtl/discrete_sched_pkg.sv
// Shared types and widths for the discrete range scheduler.
// Skip-mask support is enabled by DISCRETE_SCHED_SKIP_MASK_EN.
package discrete_sched_pkg;

  localparam int DEF_INDEX_W = 2;
  localparam int DEF_VALUE_W = 8;
  localparam int LAT_CNT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_PRESENT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/discrete_next_index.sv
// Finds the next unskipped index above k and the lowest unskipped index.
// Used only when DISCRETE_SCHED_SKIP_MASK_EN is defined.
module discrete_next_index
  import discrete_sched_pkg::*;
#(
  parameter int NUM_VARS = 4,
  parameter int INDEX_W  = DEF_INDEX_W
) (
  input  logic [NUM_VARS-1:0] i_mask,
  input  logic [INDEX_W-1:0]  i_k,
  output logic [INDEX_W-1:0]  o_next,
  output logic                o_none,
  output logic [INDEX_W-1:0]  o_lowest
);

  // Scan downward so the last hit is the smallest qualifying index.
  always_comb begin
    o_next   = '0;
    o_none   = 1'b1;
    o_lowest = '0;
    for (int i = NUM_VARS - 1; i >= 0; i--) begin
      if (!i_mask[i] && (INDEX_W'(i) > i_k)) begin
        o_next = INDEX_W'(i);
        o_none = 1'b0;
      end
      if (!i_mask[i]) o_lowest = INDEX_W'(i);
    end
  end

endmodule

// File: rtl/discrete_range_scheduler.sv
// Sweeps discrete variables through the range randomizer, one range per handshake.
// Optional skip mask: define DISCRETE_SCHED_SKIP_MASK_EN.
module discrete_range_scheduler
  import discrete_sched_pkg::*;
#(
  parameter int NUM_VARS     = 4,
  parameter int INDEX_W      = DEF_INDEX_W,
  parameter int VALUE_W      = DEF_VALUE_W,
  parameter int RAND_LATENCY = 1
) (
  input  logic                in_clock,
  input  logic                in_reset,
  input  logic                in_start,
  input  logic                in_abort,
`ifdef DISCRETE_SCHED_SKIP_MASK_EN
  input  logic [NUM_VARS-1:0] in_skip_mask,
`endif
  output logic                out_rand_enable,
  output logic [INDEX_W-1:0]  out_rand_index,
  input  logic [VALUE_W-1:0]  in_rand_start,
  input  logic [VALUE_W-1:0]  in_rand_end,
  input  logic                in_rand_equal,
  output logic                out_valid,
  input  logic                in_ready,
  output logic [INDEX_W-1:0]  out_var_index,
  output logic [VALUE_W-1:0]  out_range_start,
  output logic [VALUE_W-1:0]  out_range_end,
  output logic                out_range_equal,
  output logic                out_busy,
  output logic                out_done
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [INDEX_W-1:0]   r_k;
  logic [INDEX_W-1:0]   w_k_nxt;
  logic [LAT_CNT_W-1:0] r_cnt;
  logic [LAT_CNT_W-1:0] w_cnt_nxt;
  logic                 w_capture;
  logic [INDEX_W-1:0]   r_var_idx;
  logic [VALUE_W-1:0]   r_start;
  logic [VALUE_W-1:0]   r_end;
  logic                 r_equal;
  logic [INDEX_W-1:0]   w_next_idx;
  logic [INDEX_W-1:0]   w_lowest;
  logic                 w_last;
  logic                 w_all_skip;

`ifdef DISCRETE_SCHED_SKIP_MASK_EN
  logic [NUM_VARS-1:0] r_mask;
  logic [NUM_VARS-1:0] w_mask;

  // In IDLE the live mask picks the first index; afterwards the latched one.
  assign w_mask     = (r_state == ST_IDLE) ? in_skip_mask : r_mask;
  assign w_all_skip = &in_skip_mask;

  discrete_next_index #(
    .NUM_VARS (NUM_VARS),
    .INDEX_W  (INDEX_W)
  ) u_next_index (
    .i_mask   (w_mask),
    .i_k      (r_k),
    .o_next   (w_next_idx),
    .o_none   (w_last),
    .o_lowest (w_lowest)
  );

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      r_mask <= '0;
    end else if (r_state == ST_IDLE && in_start && !in_abort) begin
      r_mask <= in_skip_mask;
    end
  end
`else
  assign w_next_idx = r_k + INDEX_W'(1);
  assign w_last     = (r_k == INDEX_W'(NUM_VARS - 1));
  assign w_lowest   = '0;
  assign w_all_skip = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (in_start) begin
          if (w_all_skip) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ISSUE;
            w_k_nxt     = w_lowest;
          end
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = LAT_CNT_W'(RAND_LATENCY - 1);
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_PRESENT;
        end else begin
          w_cnt_nxt = r_cnt - LAT_CNT_W'(1);
        end
      end
      ST_PRESENT: begin
        if (in_ready) begin
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ISSUE;
            w_k_nxt     = w_next_idx;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    // Abort overrides everything, including a same-cycle handshake.
    if (in_abort) begin
      w_state_nxt = ST_IDLE;
      w_k_nxt     = r_k;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
    end
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      r_state   <= ST_IDLE;
      r_k       <= '0;
      r_cnt     <= '0;
      r_var_idx <= '0;
      r_start   <= '0;
      r_end     <= '0;
      r_equal   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_var_idx <= r_k;
        r_start   <= in_rand_start;
        r_end     <= in_rand_end;
        r_equal   <= in_rand_equal;
      end
    end
  end

  assign out_rand_enable = (r_state == ST_ISSUE) && !in_abort;
  assign out_rand_index  = r_k;
  assign out_valid       = (r_state == ST_PRESENT) && !in_abort;
  assign out_var_index   = r_var_idx;
  assign out_range_start = r_start;
  assign out_range_end   = r_end;
  assign out_range_equal = r_equal;
  assign out_busy        = (r_state != ST_IDLE);
  assign out_done        = (r_state == ST_DONE) && !in_abort;

endmodule

// File: tb/tb_discrete_range_scheduler.sv
// Bench for discrete_range_scheduler: latency-1 and latency-3 instances
// checked against a per-variable schedule model with random ranges/ready.
module tb_discrete_range_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ready = 1'b1;
  logic [3:0] skip = 4'b0000;

  logic [7:0] tbl_s [4];
  logic [7:0] tbl_e [4];

  logic       a_en, a_valid, a_eq, a_busy, a_done;
  logic [1:0] a_idx, a_vi;
  logic [7:0] a_s, a_e, a_in_s, a_in_e;
  logic       b_en, b_valid, b_eq, b_busy, b_done;
  logic [1:0] b_idx, b_vi;
  logic [7:0] b_s, b_e, b_in_s, b_in_e;

  // Randomizer model: combinational table lookup on index.
  assign a_in_s = tbl_s[a_idx];
  assign a_in_e = tbl_e[a_idx];
  assign b_in_s = tbl_s[b_idx];
  assign b_in_e = tbl_e[b_idx];

  discrete_range_scheduler #(.RAND_LATENCY(1)) u_a (
    .in_clock        (clk),
    .in_reset        (rst_n),
    .in_start        (start),
    .in_abort        (abort),
`ifdef DISCRETE_SCHED_SKIP_MASK_EN
    .in_skip_mask    (skip),
`endif
    .out_rand_enable (a_en),
    .out_rand_index  (a_idx),
    .in_rand_start   (a_in_s),
    .in_rand_end     (a_in_e),
    .in_rand_equal   (a_in_s == a_in_e),
    .out_valid       (a_valid),
    .in_ready        (ready),
    .out_var_index   (a_vi),
    .out_range_start (a_s),
    .out_range_end   (a_e),
    .out_range_equal (a_eq),
    .out_busy        (a_busy),
    .out_done        (a_done)
  );

  discrete_range_scheduler #(.RAND_LATENCY(3)) u_b (
    .in_clock        (clk),
    .in_reset        (rst_n),
    .in_start        (start),
    .in_abort        (abort),
`ifdef DISCRETE_SCHED_SKIP_MASK_EN
    .in_skip_mask    (skip),
`endif
    .out_rand_enable (b_en),
    .out_rand_index  (b_idx),
    .in_rand_start   (b_in_s),
    .in_rand_end     (b_in_e),
    .in_rand_equal   (b_in_s == b_in_e),
    .out_valid       (b_valid),
    .in_ready        (ready),
    .out_var_index   (b_vi),
    .out_range_start (b_s),
    .out_range_end   (b_e),
    .out_range_equal (b_eq),
    .out_busy        (b_busy),
    .out_done        (b_done)
  );

  typedef struct packed {
    logic       en;
    logic [1:0] idx;
    logic       valid;
    logic [1:0] vi;
    logic [7:0] s;
    logic [7:0] e;
    logic       eq;
    logic       busy;
    logic       done;
  } obs_t;

  int n_vec = 0;
  int n_err = 0;
  int rmode = 0;
  int bp_cnt = 0;

  function automatic obs_t get(input int w);
    obs_t o;
    if (w == 0) o = {a_en, a_idx, a_valid, a_vi, a_s, a_e, a_eq, a_busy, a_done};
    else        o = {b_en, b_idx, b_valid, b_vi, b_s, b_e, b_eq, b_busy, b_done};
    return o;
  endfunction

  // Ready driver: 0 tied high, 1 random, 2 hold low 5 cycles on index 1, 3 low.
  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0: ready = 1'b1;
      1: ready = 1'($urandom_range(0, 1));
      2: begin
        if (a_valid && a_vi == 2'd1 && bp_cnt < 5) begin
          ready = 1'b0;
          bp_cnt++;
        end else begin
          ready = 1'b1;
        end
      end
      default: ready = 1'b0;
    endcase
  end

  task automatic new_tables();
    for (int k = 0; k < 4; k++) begin
      tbl_s[k] = 8'($urandom);
      tbl_e[k] = ($urandom_range(0, 2) == 0) ? tbl_s[k] : 8'($urandom);
    end
  endtask

  // Called at a negedge; the following posedge is edge 0.
  task automatic start_sweep();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Expected schedule per visited variable: ISSUE, lat WAIT cycles,
  // PRESENT until ready; then one DONE cycle and an IDLE cycle.
  task automatic check_sweep(input int w, input int lat, input logic [3:0] vis);
    obs_t o;
    bit hs;
    int guard;
    for (int k = 0; k < 4; k++) begin
      if (!vis[k]) continue;
      @(negedge clk);
      o = get(w);
      n_vec++;
      if (o.en !== 1'b1 || o.idx !== 2'(k) || o.valid !== 1'b0 || o.busy !== 1'b1) begin
        n_err++;
        $display("FAIL issue dut%0d k%0d: en=%b idx=%0d valid=%b busy=%b, want en=1 idx=%0d valid=0 busy=1",
                 w, k, o.en, o.idx, o.valid, o.busy, k);
      end
      for (int c = 0; c < lat; c++) begin
        @(negedge clk);
        o = get(w);
        n_vec++;
        if (o.en !== 1'b0 || o.idx !== 2'(k) || o.valid !== 1'b0) begin
          n_err++;
          $display("FAIL wait dut%0d k%0d c%0d: en=%b idx=%0d valid=%b, want en=0 idx=%0d valid=0",
                   w, k, c, o.en, o.idx, o.valid, k);
        end
      end
      hs = 1'b0;
      guard = 0;
      while (!hs && guard < 60) begin
        @(negedge clk);
        o = get(w);
        n_vec++;
        if (o.valid !== 1'b1 || o.en !== 1'b0 || o.idx !== 2'(k) || o.vi !== 2'(k) ||
            o.s !== tbl_s[k] || o.e !== tbl_e[k] || o.eq !== (tbl_s[k] == tbl_e[k])) begin
          n_err++;
          $display("FAIL present dut%0d k%0d: valid=%b en=%b vi=%0d s=%h e=%h eq=%b, want valid=1 en=0 vi=%0d s=%h e=%h eq=%b",
                   w, k, o.valid, o.en, o.vi, o.s, o.e, o.eq, k, tbl_s[k], tbl_e[k],
                   tbl_s[k] == tbl_e[k]);
        end
        hs = ready;
        guard++;
      end
      if (!hs) begin
        n_vec++;
        n_err++;
        $display("FAIL handshake_timeout dut%0d k%0d: no ready in %0d cycles, want handshake", w, k, guard);
      end
    end
    @(negedge clk);
    o = get(w);
    n_vec++;
    if (o.done !== 1'b1 || o.en !== 1'b0 || o.valid !== 1'b0 || o.busy !== 1'b1) begin
      n_err++;
      $display("FAIL done dut%0d: done=%b en=%b valid=%b busy=%b, want done=1 en=0 valid=0 busy=1",
               w, o.done, o.en, o.valid, o.busy);
    end
    @(negedge clk);
    o = get(w);
    n_vec++;
    if (o.done !== 1'b0 || o.busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after dut%0d: done=%b busy=%b, want 0 0", w, o.done, o.busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      n_vec++;
      if (get(w) !== '0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: got %h, want 0", w, get(w));
      end
    end
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      n_vec++;
      if (get(w) !== '0) begin
        n_err++;
        $display("FAIL post_reset_idle dut%0d: got %h, want 0", w, get(w));
      end
    end
  endtask

  task automatic test_full_sweep();
    rmode = 0;
    new_tables();
    start_sweep();
    fork
      check_sweep(0, 1, 4'hF);
      check_sweep(1, 3, 4'hF);
    join
  endtask

  task automatic test_backpressure();
    rmode = 2;
    bp_cnt = 0;
    new_tables();
    start_sweep();
    fork
      check_sweep(0, 1, 4'hF);
      check_sweep(1, 3, 4'hF);
    join
    n_vec++;
    if (bp_cnt !== 5) begin
      n_err++;
      $display("FAIL backpressure_cycles: got %0d, want 5", bp_cnt);
    end
    rmode = 0;
  endtask

  task automatic test_back_to_back();
    rmode = 0;
    for (int s = 0; s < 2; s++) begin
      new_tables();
      start_sweep();
      fork
        check_sweep(0, 1, 4'hF);
        check_sweep(1, 3, 4'hF);
      join
    end
  endtask

  task automatic test_abort();
    rmode = 0;
    new_tables();
    start_sweep();
    repeat (7) @(posedge clk);
    #1;
    n_vec++;
    if (a_idx !== 2'd2 || a_busy !== 1'b1 || a_en !== 1'b0) begin
      n_err++;
      $display("FAIL abort_setup: idx=%0d busy=%b en=%b, want idx=2 busy=1 en=0", a_idx, a_busy, a_en);
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if (a_busy !== 1'b0 || a_done !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0 ||
          a_valid !== 1'b0 || b_valid !== 1'b0) begin
        n_err++;
        $display("FAIL abort_idle c%0d: a_busy=%b a_done=%b b_busy=%b b_done=%b, want all 0",
                 c, a_busy, a_done, b_busy, b_done);
      end
    end
    start_sweep();
    fork
      check_sweep(0, 1, 4'hF);
      check_sweep(1, 3, 4'hF);
    join
  endtask

  task automatic test_reset_mid();
    rmode = 3;
    ready = 1'b0;
    new_tables();
    start_sweep();
    repeat (3) @(negedge clk);
    n_vec++;
    if (a_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_setup: a_valid=%b, want 1", a_valid);
    end
    rst_n = 1'b0;
    #1;
    for (int w = 0; w < 2; w++) begin
      n_vec++;
      if (get(w) !== '0) begin
        n_err++;
        $display("FAIL reset_mid_outputs dut%0d: got %h, want 0", w, get(w));
      end
    end
    #1 rst_n = 1'b1;
    rmode = 0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_busy: a=%b b=%b, want 0 0", a_busy, b_busy);
    end
  endtask

`ifdef DISCRETE_SCHED_SKIP_MASK_EN
  task automatic test_skip();
    rmode = 0;
    new_tables();
    skip = 4'b0101;
    start_sweep();
    skip = 4'($urandom);
    fork
      check_sweep(0, 1, 4'b1010);
      check_sweep(1, 3, 4'b1010);
    join
    skip = 4'b1111;
    start_sweep();
    fork
      check_sweep(0, 1, 4'b0000);
      check_sweep(1, 3, 4'b0000);
    join
    skip = 4'b0000;
  endtask
`endif

  task automatic test_random();
    logic [3:0] m;
    rmode = 1;
    for (int s = 0; s < 6; s++) begin
      new_tables();
      m = 4'h0;
`ifdef DISCRETE_SCHED_SKIP_MASK_EN
      m = 4'($urandom_range(0, 14));
      skip = m;
`endif
      start_sweep();
      fork
        check_sweep(0, 1, ~m);
        check_sweep(1, 3, ~m);
        begin
          // Start while busy must be ignored.
          @(posedge clk);
          #1 start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
        end
      join
    end
    skip = 4'b0000;
    rmode = 0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      tbl_s[k] = '0;
      tbl_e[k] = '0;
    end
    test_reset();
    test_full_sweep();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid();
`ifdef DISCRETE_SCHED_SKIP_MASK_EN
    @(negedge clk);
    test_skip();
`endif
    @(negedge clk);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/discrete_range_scheduler.md
# discrete_range_scheduler

Sequencer for the discrete range randomizer. On a start pulse it walks the discrete variables in ascending index order. For each variable it:
- drives the randomizer's index;
- pulses its enable;
- waits out the random-generator latency;
- captures the selected start/end/equal range.

Each captured range goes to the downstream solver over a valid/ready handshake. A done pulse marks the end of the sweep.

## Interface
Parameters:
- NUM_VARS, 4, number of discrete variables swept
- INDEX_W, 2, variable index width (clog2 NUM_VARS)
- VALUE_W, 8, integer variable width of range bounds
- RAND_LATENCY, 1, cycles from the enable-high cycle to valid randomizer output; legal range 1..15

Ports:
- in_clock, input, 1, single clock, rising edge
- in_reset, input, 1, asynchronous active-low reset
- in_start, input, 1, start sweep; sampled only in IDLE
- in_abort, input, 1, abandon sweep; return to IDLE
- in_skip_mask, input, NUM_VARS, bit k=1 skips variable k; present only with DISCRETE_SCHED_SKIP_MASK_EN
- out_rand_enable, output, 1, enable to the randomizer
- out_rand_index, output, INDEX_W, variable index to the randomizer
- in_rand_start, input, VALUE_W, randomizer range start
- in_rand_end, input, VALUE_W, randomizer range end
- in_rand_equal, input, 1, randomizer start==end flag
- out_valid, output, 1, captured range available
- in_ready, input, 1, downstream accepts the range
- out_var_index, output, INDEX_W, variable the range belongs to
- out_range_start, output, VALUE_W, captured start
- out_range_end, output, VALUE_W, captured end
- out_range_equal, output, 1, captured equal flag
- out_busy, output, 1, high in every state except IDLE
- out_done, output, 1, one-cycle pulse when the sweep completes

## Operation
- States: IDLE, ISSUE, WAIT, PRESENT, DONE.
- IDLE:
  - in_start=1 → ISSUE with current index k = lowest unskipped index.
  - If every variable is skipped → DONE.
- ISSUE (1 cycle): out_rand_enable=1, out_rand_index=k → WAIT.
- WAIT:
  - Lasts exactly RAND_LATENCY cycles; enable low; index held at k.
  - On the last WAIT edge, capture in_rand_start, in_rand_end, in_rand_equal and out_var_index=k → PRESENT.
- PRESENT:
  - out_valid=1; all out_range_* and out_var_index stay stable until out_valid && in_ready.
  - On handshake with k the last unskipped index → DONE.
  - On handshake otherwise → ISSUE with k = next unskipped index.
- DONE (1 cycle): out_done=1 → IDLE.
- out_rand_index holds k from ISSUE through PRESENT, because the randomizer's value table is combinational on index.
- in_abort:
  - Takes effect in any state: next state IDLE, out_valid and out_rand_enable low, no out_done.
  - in_abort wins over in_start and over a same-cycle handshake; that handshake does not count.
- in_start while busy is ignored. A new sweep starts again at the lowest index.
- The WAIT counter is 4 bits and counts down from RAND_LATENCY-1 to 0; it does not wrap.

## Timing
- Reset values: state IDLE, all outputs 0, captured registers 0, k=0.
- Reset mid-sweep aborts immediately and asynchronously. No done pulse is issued.
- Cycle numbering: in_start is sampled at edge 0. ISSUE is cycle 1 and WAIT covers cycles 2..1+RAND_LATENCY.
- out_valid first rises in cycle 2+RAND_LATENCY.
- With in_ready tied high, each variable costs 2+RAND_LATENCY cycles. The variable is ISSUE → WAIT → PRESENT; its handshake cycle is its PRESENT cycle.
- out_done rises in the cycle after the final handshake.
- Back-to-back sweeps: in_start is accepted in the first IDLE cycle after DONE.

## Configuration
- DISCRETE_SCHED_SKIP_MASK_EN defined:
  - in_skip_mask exists and is registered on in_start acceptance.
  - Changes to it mid-sweep have no effect.
  - Skipped indices are never issued.
- Undefined: the port is absent and all NUM_VARS variables are visited in order.

## Structure
- Package discrete_sched_pkg contains:
  - state enum (IDLE, ISSUE, WAIT, PRESENT, DONE);
  - INDEX_W and VALUE_W defaults;
  - latency counter width constant.
- Sub-module discrete_next_index (combinational): inputs mask and current k; outputs next unskipped index above k, a "none" flag, and the lowest unskipped index. It is instantiated only with DISCRETE_SCHED_SKIP_MASK_EN; without the macro, k+1 with last = (k==NUM_VARS-1).

## Test plan
- Full sweep: defaults, in_ready=1, start pulse.
  - Enable pulses at cycles 1, 4, 7, 10 with indices 0..3.
  - out_valid in cycles 3, 6, 9, 12.
  - out_done in cycle 13.
- Backpressure: in_ready low for 5 cycles while out_valid=1 for index 1 → outputs stable, no new enable, sweep resumes on ready.
- Latency: RAND_LATENCY=3 → out_valid first in cycle 5; captured range matches randomizer outputs sampled at the end of cycle 4.
- Skip mask (macro on): mask 4'b0101 → only indices 1 and 3 issued. Mask 4'b1111 → out_done in the cycle after the start edge, no enable.
- Abort: in_abort in WAIT of index 2 → IDLE next cycle, no out_done. A following start → index 0 reissued.
- Async reset asserted during PRESENT → all outputs 0 immediately; after release, busy stays low until in_start.
